// File: rtl/i2c_master_wr.sv
// i2c_master_wr
//   Single-shot I2C write initiator: START, {slave_addr,W}, mem_addr, wr_data,
//   STOP. The target's ACK is sampled after each byte; a NACK aborts straight
//   to STOP and is reported through ack_err together with done.
//
// Ports
//   clk, rst_n   system clock, synchronous active-low reset
//   start        request pulse, accepted only when idle (busy=0, done=0)
//   slave_addr   7-bit target address, latched on acceptance
//   mem_addr     memory/register address byte, latched on acceptance
//   wr_data      data byte, latched on acceptance
//   busy         transaction in progress
//   done         one-clock pulse at transaction end
//   ack_err      at least one ACK slot read 1 (valid with done)
//   scl_oe       1 = pull SCL low, 0 = release
//   sda_oe       1 = pull SDA low, 0 = release
//   sda_i        SDA pad input, used for ACK sampling
module i2c_master_wr #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic [7:0] mem_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_START = 4'd1;
    localparam logic [3:0] ST_ADDR  = 4'd2;
    localparam logic [3:0] ST_ACK1  = 4'd3;
    localparam logic [3:0] ST_MADDR = 4'd4;
    localparam logic [3:0] ST_ACK2  = 4'd5;
    localparam logic [3:0] ST_DATA  = 4'd6;
    localparam logic [3:0] ST_ACK3  = 4'd7;
    localparam logic [3:0] ST_STOP  = 4'd8;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [3:0]  state;
    logic [3:0]  nxt_state;
    logic [15:0] div_cnt;
    logic [1:0]  qtr;
    logic [1:0]  nxt_qtr;
    logic [2:0]  bit_cnt;
    logic [6:0]  addr_r;
    logic [7:0]  maddr_r;
    logic [7:0]  data_r;
    logic        ack_bit;
    logic        nack_seen;

    logic        tick;
    logic        cell_end;
    logic        accept;
    logic        in_byte;
    logic        in_ack;
    logic [7:0]  cur_byte;
    logic        scl_nxt;
    logic        sda_cur;

    assign tick     = (div_cnt == DIV_LAST);
    assign cell_end = tick && (qtr == 2'd3);
    assign accept   = (state == ST_IDLE) && start && !done;
    assign in_byte  = (state == ST_ADDR) || (state == ST_MADDR) || (state == ST_DATA);
    assign in_ack   = (state == ST_ACK1) || (state == ST_ACK2) || (state == ST_ACK3);

    always_comb begin
        cur_byte = data_r;
        case (state)
            ST_ADDR:  cur_byte = {addr_r, 1'b0};
            ST_MADDR: cur_byte = maddr_r;
            default:  cur_byte = data_r;
        endcase
    end

    always_comb begin
        nxt_state = state;
        if (state == ST_IDLE) begin
            if (accept) nxt_state = ST_START;
        end else if (cell_end) begin
            case (state)
                ST_START: nxt_state = ST_ADDR;
                ST_ADDR:  if (bit_cnt == 3'd0) nxt_state = ST_ACK1;
                ST_ACK1:  nxt_state = ack_bit ? ST_STOP : ST_MADDR;
                ST_MADDR: if (bit_cnt == 3'd0) nxt_state = ST_ACK2;
                ST_ACK2:  nxt_state = ack_bit ? ST_STOP : ST_DATA;
                ST_DATA:  if (bit_cnt == 3'd0) nxt_state = ST_ACK3;
                ST_ACK3:  nxt_state = ST_STOP;
                default:  nxt_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        nxt_qtr = qtr;
        if (state == ST_IDLE) nxt_qtr = 2'd0;
        else if (tick)        nxt_qtr = 2'(qtr + 2'd1);
    end

    // SCL follows the next-state so it changes exactly on quarter boundaries.
    assign scl_nxt = (nxt_state != ST_IDLE) && (nxt_state != ST_START) && !nxt_qtr[1];

    // SDA is derived from the current state and therefore lags SCL by one
    // clock: it moves one clk after SCL falls, giving a one-clock hold.
    always_comb begin
        sda_cur = 1'b0;
        case (state)
            ST_START: sda_cur = qtr[1];
            ST_ADDR,
            ST_MADDR,
            ST_DATA:  sda_cur = ~cur_byte[bit_cnt];
            ST_STOP:  sda_cur = (qtr != 2'd3);
            default:  sda_cur = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            addr_r    <= '0;
            maddr_r   <= '0;
            data_r    <= '0;
            ack_bit   <= 1'b0;
            nack_seen <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            state  <= nxt_state;
            qtr    <= nxt_qtr;
            busy   <= (nxt_state != ST_IDLE);
            done   <= (state == ST_STOP) && cell_end;
            scl_oe <= scl_nxt;
            sda_oe <= sda_cur;

            if (state == ST_IDLE || tick) div_cnt <= '0;
            else                          div_cnt <= div_cnt + 16'd1;

            if (accept) begin
                addr_r    <= slave_addr;
                maddr_r   <= mem_addr;
                data_r    <= wr_data;
                bit_cnt   <= 3'd7;
                nack_seen <= 1'b0;
                ack_err   <= 1'b0;
            end

            if (in_ack && qtr == 2'd2 && tick) ack_bit <= sda_i;

            if (cell_end) begin
                // Bit counter wraps 0 -> 7, ready for the next byte.
                if (in_byte)          bit_cnt   <= bit_cnt - 3'd1;
                if (in_ack && ack_bit) nack_seen <= 1'b1;
                if (state == ST_STOP) ack_err   <= nack_seen;
            end
        end
    end

endmodule
